// File: rtl/color_frame_arbiter_if.sv
// Pixel-flag stream in, debounced colour decision and frame statistics out.
interface color_frame_arbiter_if #(
    parameter int CNT_W = 17
);
    logic             sof;
    logic             pix_valid;
    logic             is_red;
    logic             is_green;
    logic             is_black;
    logic [1:0]       result;
    logic             result_valid;
    logic             result_ready;
    logic [CNT_W-1:0] red_cnt;
    logic [CNT_W-1:0] green_cnt;
    logic [CNT_W-1:0] black_cnt;
    logic             frame_drop;
    logic             busy;

    modport master (
        output sof, pix_valid, is_red, is_green, is_black, result_ready,
        input  result, result_valid, red_cnt, green_cnt, black_cnt, frame_drop, busy
    );

    modport slave (
        input  sof, pix_valid, is_red, is_green, is_black, result_ready,
        output result, result_valid, red_cnt, green_cnt, black_cnt, frame_drop, busy
    );
endinterface

// File: rtl/color_frame_arbiter.sv
// Frame-level colour scheduler: counts ROI flags per frame, picks the dominant
// colour, debounces it over consecutive frames and offers it downstream.
module color_frame_arbiter #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int ROI_X0   = 160,
    parameter int ROI_X1   = 479,
    parameter int ROI_Y0   = 120,
    parameter int ROI_Y1   = 359,
    parameter int MIN_PIX  = 2000,
    parameter int N_STABLE = 3,
    parameter int CNT_W    = 17
) (
    input logic                  clk,
    input logic                  reset_n,
    color_frame_arbiter_if.slave bus
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int SW = $clog2(N_STABLE + 1);

    localparam logic [XW-1:0]    X_LAST   = XW'(IMG_W - 1);
    localparam logic [XW-1:0]    RX0      = XW'(ROI_X0);
    localparam logic [XW-1:0]    RX1      = XW'(ROI_X1);
    localparam logic [YW-1:0]    Y_LAST   = YW'(IMG_H - 1);
    localparam logic [YW-1:0]    RY0      = YW'(ROI_Y0);
    localparam logic [YW-1:0]    RY1      = YW'(ROI_Y1);
    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_PIX);
    localparam logic [SW-1:0]    STAB_MAX = SW'(N_STABLE);

    typedef enum logic [1:0] {WAIT_SOF, ACCUM, DECIDE, HOLD} state_t;

    state_t           state, state_n;
    logic [XW-1:0]    x, x_n, px;
    logic [YW-1:0]    y, y_n, py;
    logic [CNT_W-1:0] acc_r, acc_g, acc_b, acc_r_n, acc_g_n, acc_b_n;
    logic [CNT_W-1:0] cnt_r, cnt_g, cnt_b, cnt_r_n, cnt_g_n, cnt_b_n;
    logic [CNT_W-1:0] best;
    logic [1:0]       winner, last_win, last_win_n, result_q, result_n;
    logic [SW-1:0]    stab, stab_n;
    logic             rvalid_q, rvalid_n, drop_q, drop_n, busy_q;
    logic             new_frame, take_pix, in_roi, last_pix;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic hit);
        return (hit && (v != '1)) ? v + 1'b1 : v;
    endfunction

    // A sof pixel always restarts the raster at (0,0), whatever the counters say.
    assign new_frame = bus.pix_valid & bus.sof;
    assign take_pix  = ((state == WAIT_SOF) && new_frame) || ((state == ACCUM) && bus.pix_valid);
    assign px        = new_frame ? '0 : x;
    assign py        = new_frame ? '0 : y;
    assign in_roi    = (px >= RX0) && (px <= RX1) && (py >= RY0) && (py <= RY1);
    assign last_pix  = (px == X_LAST) && (py == Y_LAST);

    // Frame winner: largest eligible count; strict > keeps red > green > black on ties.
    always_comb begin
        winner = 2'd0;
        best   = '0;
        if (acc_r >= MIN_CNT) begin
            winner = 2'd1;
            best   = acc_r;
        end
        if ((acc_g >= MIN_CNT) && ((winner == 2'd0) || (acc_g > best))) begin
            winner = 2'd2;
            best   = acc_g;
        end
        if ((acc_b >= MIN_CNT) && ((winner == 2'd0) || (acc_b > best))) begin
            winner = 2'd3;
            best   = acc_b;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n    = state;
        x_n        = x;
        y_n        = y;
        acc_r_n    = acc_r;
        acc_g_n    = acc_g;
        acc_b_n    = acc_b;
        cnt_r_n    = cnt_r;
        cnt_g_n    = cnt_g;
        cnt_b_n    = cnt_b;
        last_win_n = last_win;
        stab_n     = stab;
        result_n   = result_q;
        rvalid_n   = rvalid_q;
        drop_n     = 1'b0;

        if (take_pix) begin
            acc_r_n = sat_inc(new_frame ? '0 : acc_r, in_roi & bus.is_red);
            acc_g_n = sat_inc(new_frame ? '0 : acc_g, in_roi & bus.is_green);
            acc_b_n = sat_inc(new_frame ? '0 : acc_b, in_roi & bus.is_black);
            x_n     = (px == X_LAST) ? '0 : px + 1'b1;
            y_n     = (px == X_LAST) ? py + 1'b1 : py;
            state_n = last_pix ? DECIDE : ACCUM;
            drop_n  = (state == ACCUM) && new_frame;
        end

        case (state)
            DECIDE: begin
                cnt_r_n = acc_r;
                cnt_g_n = acc_g;
                cnt_b_n = acc_b;
                if (winner == last_win) begin
                    if (stab != STAB_MAX) stab_n = stab + 1'b1;
                end else begin
                    last_win_n = winner;
                    stab_n     = SW'(1);
                end
                if ((stab_n == STAB_MAX) && (winner != result_q)) begin
                    result_n = winner;
                    rvalid_n = 1'b1;
                    state_n  = HOLD;
                end else begin
                    state_n  = WAIT_SOF;
                end
            end
            HOLD: begin
                // Any frame starting while the result is parked is discarded whole.
                drop_n = new_frame;
                if (bus.result_ready) begin
                    rvalid_n = 1'b0;
                    state_n  = WAIT_SOF;
                end
            end
            default: ;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= WAIT_SOF;
            x        <= '0;
            y        <= '0;
            acc_r    <= '0;
            acc_g    <= '0;
            acc_b    <= '0;
            cnt_r    <= '0;
            cnt_g    <= '0;
            cnt_b    <= '0;
            last_win <= 2'd0;
            stab     <= '0;
            result_q <= 2'd0;
            rvalid_q <= 1'b0;
            drop_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            x        <= x_n;
            y        <= y_n;
            acc_r    <= acc_r_n;
            acc_g    <= acc_g_n;
            acc_b    <= acc_b_n;
            cnt_r    <= cnt_r_n;
            cnt_g    <= cnt_g_n;
            cnt_b    <= cnt_b_n;
            last_win <= last_win_n;
            stab     <= stab_n;
            result_q <= result_n;
            rvalid_q <= rvalid_n;
            drop_q   <= drop_n;
            busy_q   <= (state_n != WAIT_SOF);
        end
    end

    assign bus.result       = result_q;
    assign bus.result_valid = rvalid_q;
    assign bus.red_cnt      = cnt_r;
    assign bus.green_cnt    = cnt_g;
    assign bus.black_cnt    = cnt_b;
    assign bus.frame_drop   = drop_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_color_frame_arbiter.sv
// Bench for color_frame_arbiter on a shrunken 16x12 image with an 8x6 ROI.
module tb_color_frame_arbiter;
    localparam int W = 16, H = 12, X0 = 4, X1 = 11, Y0 = 3, Y1 = 8;
    localparam int MINP = 10, NS = 3, CW = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    color_frame_arbiter_if #(.CNT_W(CW)) bus ();

    color_frame_arbiter #(
        .IMG_W(W), .IMG_H(H), .ROI_X0(X0), .ROI_X1(X1), .ROI_Y0(Y0), .ROI_Y1(Y1),
        .MIN_PIX(MINP), .N_STABLE(NS), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int rdy_mode = 0;
    bit bubbles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    int m_cnt[3];
    int m_p;
    bit m_in, m_dec, m_hold;
    int e_res, e_val, e_drop, e_busy;
    int e_cnt[3];
    int hist[$];

    task automatic m_reset();
        m_cnt = '{0, 0, 0};
        e_cnt = '{0, 0, 0};
        m_p = 0; m_in = 0; m_dec = 0; m_hold = 0;
        e_res = 0; e_val = 0; e_drop = 0; e_busy = 0;
        hist.delete();
    endtask

    task automatic m_decide();
        int win, best, run;
        e_cnt = m_cnt;
        win = 0; best = -1;
        for (int c = 0; c < 3; c++)
            if (m_cnt[c] >= MINP && m_cnt[c] > best) begin
                win = c + 1;
                best = m_cnt[c];
            end
        hist.push_back(win);
        if (hist.size() > NS) void'(hist.pop_front());
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != win) break;
            run++;
        end
        if (run >= NS && win != e_res) begin
            e_res = win;
            e_val = 1;
            m_hold = 1;
        end
    endtask

    task automatic m_step();
        bit sp;
        int x, y;
        logic [2:0] fl;
        sp = bus.pix_valid && bus.sof;
        fl = {bus.is_red, bus.is_green, bus.is_black};
        e_drop = 0;
        if (m_dec) begin
            m_decide();
            m_dec = 0;
        end else if (m_hold) begin
            if (sp) e_drop = 1;
            if (bus.result_ready) begin
                m_hold = 0;
                e_val = 0;
            end
        end else begin
            if (sp) begin
                if (m_in) e_drop = 1;
                m_in = 1;
                m_p = 0;
                m_cnt = '{0, 0, 0};
            end
            if (m_in && bus.pix_valid) begin
                x = m_p % W;
                y = m_p / W;
                if (x >= X0 && x <= X1 && y >= Y0 && y <= Y1)
                    for (int c = 0; c < 3; c++)
                        if (fl[2-c] && m_cnt[c] < CMAX) m_cnt[c]++;
                m_p++;
                if (m_p == W * H) begin
                    m_in = 0;
                    m_dec = 1;
                end
            end
        end
        e_busy = (m_in || m_dec || m_hold) ? 1 : 0;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) m_reset();
            else m_step();
        end
    end

    // Compare every cycle, half a period away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("m_result", bus.result, e_res);
            check("m_valid", bus.result_valid, e_val);
            check("m_red_cnt", bus.red_cnt, e_cnt[0]);
            check("m_green_cnt", bus.green_cnt, e_cnt[1]);
            check("m_black_cnt", bus.black_cnt, e_cnt[2]);
            check("m_drop", bus.frame_drop, e_drop);
            check("m_busy", bus.busy, e_busy);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [2:0] pattern(input int mode, input int x, input int y);
        logic r, g, b;
        r = 0; g = 0; b = 0;
        case (mode)
            0: r = 1;
            1: begin r = $urandom % 2; g = $urandom % 2; b = $urandom % 2; end
            2: r = (x < X0);
            3: begin r = (x % 2 == 0); g = (x % 2 == 0); end
            4: r = (y == Y0);
            5: g = 1;
            6: begin b = 1; r = ($urandom % 4 == 0); end
            7: begin
                r = (x == X1 && y == Y1) || (x == X1 + 1 && y == Y1);
                b = (x == X0 && y == Y0) || (x == X0 && y == Y0 - 1);
            end
            default: ;
        endcase
        return {r, g, b};
    endfunction

    task automatic step(input bit s, input bit v, input bit r, input bit g, input bit b);
        bus.sof = s;
        bus.pix_valid = v;
        bus.is_red = r;
        bus.is_green = g;
        bus.is_black = b;
        case (rdy_mode)
            0: bus.result_ready = 1'b0;
            1: bus.result_ready = 1'b1;
            default: bus.result_ready = 1'($urandom % 2);
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic send_frame(input int mode, input int stop_at, input bit chk_drop);
        logic [2:0] f;
        for (int p = 0; p < W * H; p++) begin
            if (p == stop_at) return;
            f = pattern(mode, p % W, p / W);
            if (bubbles && p != 0 && ($urandom % 8 == 0)) step(0, 0, 1, 1, 1);
            step(p == 0, 1, f[2], f[1], f[0]);
            if (chk_drop && p == 0) check("drop_midframe", bus.frame_drop, 1);
        end
    endtask

    initial begin
        int mode, reps, modes[8];
        modes = '{0, 1, 1, 5, 6, 3, 4, 1};
        bus.sof = 0; bus.pix_valid = 0; bus.is_red = 0; bus.is_green = 0;
        bus.is_black = 0; bus.result_ready = 0;
        #1 reset_n = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", bus.result, 0);
        check("rst_valid", bus.result_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_red_cnt", bus.red_cnt, 0);
        check("rst_drop", bus.frame_drop, 0);
        reset_n = 1;

        // Reset in the middle of an accumulating frame.
        send_frame(0, 6 * W, 0);
        check("busy_accum", bus.busy, 1);
        #2 reset_n = 0;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_valid", bus.result_valid, 0);
        check("midrst_red", bus.red_cnt, 0);
        @(posedge clk);
        #1 reset_n = 1;
        repeat (5) step(0, 1, 1, 0, 0);
        check("no_sof_idle", bus.busy, 0);

        // Three full red frames: result only after the third, two cycles after its last pixel.
        for (int f = 0; f < 3; f++) begin
            send_frame(0, -1, 0);
            check("red_valid_decide", bus.result_valid, 0);
            idle(1);
            check("red_cnt_full", bus.red_cnt, 48);
            check("red_valid_after", bus.result_valid, (f == 2) ? 1 : 0);
            idle(1);
        end
        check("red_result", bus.result, 1);

        // sof while parked in HOLD is dropped; result stays put.
        step(1, 1, 1, 0, 0);
        check("hold_drop", bus.frame_drop, 1);
        check("hold_valid", bus.result_valid, 1);
        check("hold_result", bus.result, 1);
        step(0, 1, 1, 0, 0);
        check("hold_drop_pulse", bus.frame_drop, 0);
        rdy_mode = 1;
        idle(1);
        check("accept_valid", bus.result_valid, 0);
        check("accept_busy", bus.busy, 0);

        // Green takes over, then a red/green tie resolves to red.
        for (int f = 0; f < 3; f++) begin send_frame(5, -1, 0); idle(1); end
        check("green_cnt", bus.green_cnt, 48);
        check("green_result", bus.result, 2);
        check("green_valid", bus.result_valid, 1);
        idle(2);
        for (int f = 0; f < 3; f++) begin send_frame(3, -1, 0); idle(1); end
        check("tie_red_cnt", bus.red_cnt, 24);
        check("tie_green_cnt", bus.green_cnt, 24);
        check("tie_result", bus.result, 1);
        idle(2);

        // Below MIN_PIX everywhere -> no colour.
        for (int f = 0; f < 3; f++) begin send_frame(4, -1, 0); idle(1); end
        check("minpix_red_cnt", bus.red_cnt, 8);
        check("minpix_result", bus.result, 0);
        check("minpix_valid", bus.result_valid, 1);
        idle(2);

        // ROI boundaries.
        send_frame(2, -1, 0); idle(1);
        check("outside_roi_red", bus.red_cnt, 0);
        idle(1);
        send_frame(7, -1, 0); idle(1);
        check("corner_red", bus.red_cnt, 1);
        check("corner_black", bus.black_cnt, 1);
        idle(1);

        // Mid-frame restart at pixel (10,5).
        send_frame(0, 5 * W + 10, 0);
        send_frame(0, -1, 1);
        idle(1);
        check("restart_red_cnt", bus.red_cnt, 48);
        idle(2);

        // Randomised traffic against the model.
        rdy_mode = 2;
        bubbles = 1;
        for (int i = 0; i < 45; i++) begin
            mode = modes[$urandom % 8];
            reps = $urandom_range(1, 4);
            for (int r = 0; r < reps; r++) begin
                if ($urandom % 6 == 0) begin
                    send_frame(mode, $urandom_range(1, W * H - 1), 0);
                    if ($urandom % 2 == 0) idle($urandom_range(1, 3));
                end else begin
                    send_frame(mode, -1, 0);
                    idle($urandom_range(1, 3));
                end
            end
        end
        rdy_mode = 1;
        bubbles = 0;
        idle(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
